// File: rtl/r_i_cpu_pkg.sv
// Shared encodings for the multi-cycle R/I-type CPU: opcodes, functs, FSM states, ALU ops
// and the instruction decoder used by the EXEC stage.
package r_i_cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu, AluLui
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    imm_sext;
    logic    ov_chk;    // overflow suppresses writeback (add/sub/addi)
    logic    dest_rt;
  } alu_ctrl_t;

  function automatic logic is_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    if (ins[31:26] == OpRtype) begin
      case (ins[5:0])
        FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSltu: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      ok = (ins[31:26] >= OpAddi) && (ins[31:26] <= OpLui);
    end
    return ok;
  endfunction

  function automatic alu_ctrl_t decode(input logic [31:0] ins);
    alu_ctrl_t d;
    d.op       = AluAdd;
    d.use_imm  = 1'b1;
    d.imm_sext = 1'b0;
    d.ov_chk   = 1'b0;
    d.dest_rt  = 1'b1;
    if (ins[31:26] == OpRtype) begin
      d.use_imm = 1'b0;
      d.dest_rt = 1'b0;
      case (ins[5:0])
        FnAdd:   begin d.op = AluAdd; d.ov_chk = 1'b1; end
        FnAddu:  d.op = AluAdd;
        FnSub:   begin d.op = AluSub; d.ov_chk = 1'b1; end
        FnSubu:  d.op = AluSub;
        FnAnd:   d.op = AluAnd;
        FnOr:    d.op = AluOr;
        FnXor:   d.op = AluXor;
        FnNor:   d.op = AluNor;
        FnSlt:   d.op = AluSlt;
        FnSltu:  d.op = AluSltu;
        default: d.op = AluAdd;
      endcase
    end else begin
      case (ins[31:26])
        OpAddi:  begin d.op = AluAdd; d.imm_sext = 1'b1; d.ov_chk = 1'b1; end
        OpAddiu: begin d.op = AluAdd; d.imm_sext = 1'b1; end
        OpSlti:  begin d.op = AluSlt; d.imm_sext = 1'b1; end
        OpSltiu: begin d.op = AluSltu; d.imm_sext = 1'b1; end
        OpAndi:  d.op = AluAnd;
        OpOri:   d.op = AluOr;
        OpXori:  d.op = AluXor;
        OpLui:   d.op = AluLui;
        default: d.op = AluAdd;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/r_i_alu.sv
// Combinational DATA_W-bit ALU; overflow is reported for add/sub, the caller decides
// whether it matters.
module r_i_alu
  import r_i_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_of,
  output logic              o_zf
);

  localparam int unsigned Msb = DATA_W - 1;

  logic [DATA_W-1:0] w_sum, w_diff;
  logic w_add_of, w_sub_of, w_slt, w_sltu;

  assign w_sum    = i_a + i_b;
  assign w_diff   = i_a - i_b;
  assign w_add_of = (i_a[Msb] == i_b[Msb]) && (w_sum[Msb] != i_a[Msb]);
  assign w_sub_of = (i_a[Msb] != i_b[Msb]) && (w_diff[Msb] != i_a[Msb]);
  assign w_slt    = $signed(i_a) < $signed(i_b);
  assign w_sltu   = i_a < i_b;

  always_comb begin
    o_result = '0;
    o_of     = 1'b0;
    case (i_op)
      AluAdd:  begin o_result = w_sum;  o_of = w_add_of; end
      AluSub:  begin o_result = w_diff; o_of = w_sub_of; end
      AluAnd:  o_result = i_a & i_b;
      AluOr:   o_result = i_a | i_b;
      AluXor:  o_result = i_a ^ i_b;
      AluNor:  o_result = ~(i_a | i_b);
      AluSlt:  o_result = {{(DATA_W-1){1'b0}}, w_slt};
      AluSltu: o_result = {{(DATA_W-1){1'b0}}, w_sltu};
      AluLui:  o_result = i_b << (DATA_W - 16);
      default: o_result = '0;
    endcase
  end

  assign o_zf = (o_result == '0);

endmodule

// File: rtl/r_i_cpu_mc.sv
// Multi-cycle R/I-type CPU: FETCH/DECODE/EXEC/WB sequencer, 32-entry register file,
// illegal-opcode halt and retire strobe.
module r_i_cpu_mc
  import r_i_cpu_pkg::*;
#(
  parameter int unsigned     DATA_W   = 32,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              en,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              ofa,
  output logic              zfa,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              retire,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_e            r_state, w_state_d;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_douta, r_doutb;
  logic              r_ofa, r_zfa;
  logic [DATA_W-1:0] r_rf [32];

  alu_ctrl_t         w_ctrl;
  logic [DATA_W-1:0] w_imm, w_alu_b, w_alu_res;
  logic              w_alu_of, w_alu_zf, w_id_legal, w_wb_we;
  logic [4:0]        w_dest;

  assign w_id_legal = is_legal(imem_rdata);
  assign w_ctrl     = decode(r_ir);
  assign w_imm      = w_ctrl.imm_sext ? DATA_W'($signed(r_ir[15:0])) : DATA_W'(r_ir[15:0]);
  assign w_alu_b    = w_ctrl.use_imm ? w_imm : r_b;
  assign w_dest     = w_ctrl.dest_rt ? r_ir[20:16] : r_ir[15:11];
  // r_ofa is only ever set by overflow-checked ops, so it alone gates the write.
  assign w_wb_we    = (r_state == StWb) && (w_dest != 5'd0) && !r_ofa;

  r_i_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (w_alu_b),
    .i_op     (w_ctrl.op),
    .o_result (w_alu_res),
    .o_of     (w_alu_of),
    .o_zf     (w_alu_zf)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StFetch:  if (en) w_state_d = StDecode;
      StDecode: w_state_d = w_id_legal ? StExec : StHalt;
      StExec:   w_state_d = StWb;
      StWb:     w_state_d = StFetch;
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StFetch;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_douta <= '0;
      r_doutb <= '0;
      r_ofa   <= 1'b0;
      r_zfa   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StDecode: begin
          r_ir <= imem_rdata;
          r_a  <= r_rf[imem_rdata[25:21]];
          r_b  <= r_rf[imem_rdata[20:16]];
        end
        StExec: begin
          r_douta <= w_alu_res;
          r_doutb <= r_b;
          r_zfa   <= w_alu_zf;
          r_ofa   <= w_alu_of & w_ctrl.ov_chk;
        end
        StWb:    r_pc <= r_pc + PC_W'(4);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[w_dest] <= r_douta;
    end
  end

  // Gated by rsta so the strobe is quiet while reset is held.
  assign imem_en   = (r_state == StFetch) && en && !rsta;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign retire    = (r_state == StWb);
  assign halted    = (r_state == StHalt);
  assign douta     = r_douta;
  assign doutb     = r_doutb;
  assign ofa       = r_ofa;
  assign zfa       = r_zfa;

endmodule

// File: doc/r_i_cpu_mc.md
Name: r_i_cpu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle R/I-type CPU. Executes the MIPS-encoded R-type ALU and I-type immediate subset from an external synchronous instruction memory.
- Adds over the previous generation:
  - configurable data width and reset PC;
  - an explicit FETCH/DECODE/EXEC/WB state machine with fetch stall;
  - overflow-suppressed writeback;
  - an illegal-opcode halt;
  - a retire strobe.
- Sits between the instruction BRAM and the board debug outputs (douta/doutb/flags).

Parameters:
- DATA_W, 32, datapath and register width; legal range 16..64.
- PC_W, 32, program counter width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clka  in  1  system clock, rising edge.
- rsta  in  1  asynchronous active-high reset.
- en  in  1  fetch enable; low stalls in FETCH.
- imem_en  out  1  instruction read strobe.
- imem_addr  out  PC_W  byte address of the instruction (equals pc).
- imem_rdata  in  32  instruction word, valid one cycle after imem_en.
- ofa  out  1  signed-overflow flag of the last EXEC.
- zfa  out  1  zero flag of the last EXEC.
- douta  out  DATA_W  registered ALU result.
- doutb  out  DATA_W  registered rt operand.
- retire  out  1  one-cycle pulse in WB.
- halted  out  1  sticky illegal-instruction flag.
- pc  out  PC_W  current program counter.

Behaviour:
- Reset (async, rsta=1):
  - state=FETCH, pc=RESET_PC;
  - ir, A, B, douta, doutb, ofa, zfa, retire, halted, imem_en all 0;
  - all 32 registers cleared.
  - Reset asserted mid-instruction aborts it with no writeback.
- FETCH:
  - if en=1: imem_en=1, imem_addr=pc, go to DECODE;
  - else: imem_en=0, stay in FETCH.
- DECODE:
  - ir<=imem_rdata; A<=R[rs]; B<=R[rt] (read from imem_rdata fields directly);
  - legal -> EXEC; illegal -> HALT.
- EXEC:
  - douta<=ALU result, doutb<=B;
  - zfa<=(result==0);
  - ofa<=signed overflow for add/sub/addi only, else 0;
  - go to WB.
- WB:
  - write R[dest]<=douta unless dest==0 or (ofa=1 on add/sub/addi);
  - pc<=pc+4 (wraps modulo 2^PC_W);
  - retire=1 for this cycle only;
  - go to FETCH.
- Throughput: 4 cycles per instruction when en is held high.
- HALT:
  - halted=1, imem_en=0, pc frozen, no register writes;
  - ofa/zfa/douta/doutb hold their values;
  - only rsta exits.
- R-type (opcode 0x00, dest=rd), funct values:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu;
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor;
  - 0x2A slt, 0x2B sltu.
  - Any other funct is illegal.
- I-type (dest=rt):
  - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu: sign-extended imm;
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extended imm;
  - 0x0F lui: result = {imm, (DATA_W-16) zeros}.
  - Any other opcode is illegal.
- Width rules:
  - all arithmetic is DATA_W bits, modulo;
  - slt/sltu result is 1 or 0 zero-extended;
  - overflow = operand signs equal (after negating B for sub) and result sign differs.
- Register 0 reads as 0 always. Same-instruction read/write hazards cannot occur (multi-cycle).
- imem_rdata is ignored outside DECODE.

Decomposition:
- Package r_i_cpu_pkg:
  - opcode and funct localparams;
  - state encoding (FETCH, DECODE, EXEC, WB, HALT);
  - ALU-op enum.
- Sub-module r_i_alu: combinational, DATA_W-parametrised; inputs A, B, alu_op; outputs result, of, zf.
- Register file and FSM stay inside r_i_cpu_mc.

Test Plan:
- Reset mid-EXEC of addi $1,$0,5 (0x20010005) -> no write ($1=0), pc=RESET_PC, all outputs 0, next cycle imem_en=1 with en=1.
- Overflow: lui $1,0x7FFF; ori $1,$1,0xFFFF; addi $2,$1,1 -> third instruction douta=0x80000000, ofa=1, $2 stays 0, retire pulses; a following addu $3,$1,$1 gives ofa=0 and $3=0xFFFFFFFE.
- Zero/compare: addi $4,$0,-1 (0x2004FFFF); sub $5,$4,$4 -> douta=0, zfa=1; slt $6,$4,$0 -> 1; sltu $6,$4,$0 -> 0; sltiu $7,$0,-1 -> 1.
- $0 protection: addi $0,$0,5 then or $8,$0,$0 -> douta=0, zfa=1; retire pulses exactly every 4 cycles.
- Stall and halt:
  - en=0 for 10 cycles in FETCH -> imem_en=0, pc unchanged; resumes on en=1.
  - Opcode 0x23 (0x8C220000) -> halted=1 after DECODE, imem_en stays 0, pc frozen for 20 cycles until rsta.
- DATA_W=16 instance: lui $1,0xABCD -> douta=0xABCD; addi $2,$1,0x7FFF -> douta=0x2BCC, ofa=0; RESET_PC=0x100 -> first imem_addr=0x100.
